// File: rtl/shift_unit_seq.sv
// Sequential multi-mode shifter (LSL/LSR/ASR/ROR), one single-bit shift per clock.
// Latency: N+1 edges from the start capture to done, where N is the clamped/reduced amount.
// Backpressure: start is only sampled in IDLE; busy is high while an operation is in flight.
module shift_unit_seq #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [AMT_W-1:0] FULL_CNT = AMT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [1:0]       op_mode;
    logic [AMT_W-1:0] count;
    logic [AMT_W-1:0] load_cnt;
    logic [WIDTH:0]   step;

    // One single-bit shift of val; returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift1(input logic [1:0] m, input logic [WIDTH-1:0] val);
        logic [WIDTH:0] r;
        case (m)
            MODE_LSL: r = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            MODE_LSR: r = {val[0], 1'b0, val[WIDTH-1:1]};
            MODE_ASR: r = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            default:  r = {val[0], val[0], val[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Rotates wrap modulo WIDTH; linear shifts saturate at WIDTH since further shifts change nothing useful.
    always_comb begin
        load_cnt = amount;
        if (mode == MODE_ROR) begin
            load_cnt = {1'b0, amount[SH_W-1:0]};
        end else if (amount > FULL_CNT) begin
            load_cnt = FULL_CNT;
        end
    end

    // Next shifted value of the working register under the captured mode.
    always_comb begin
        step = shift1(op_mode, result);
    end

    // Control FSM with registered busy/done; result and carry_out only move on capture and shift edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_mode   <= MODE_LSL;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        result    <= data_in;
                        op_mode   <= mode;
                        carry_out <= 1'b0;
                        count     <= load_cnt;
                        busy      <= 1'b1;
                        if (load_cnt != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    result    <= step[WIDTH-1:0];
                    carry_out <= step[WIDTH];
                    count     <= count - 1'b1;
                    if (count == AMT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=8) with an expectation queue.
// Expected result/carry/latency are pushed at issue time and popped when done is seen.
// Start is held across an operation to probe the IDLE-only acceptance rule.
module tb_shift_unit_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        int               lat;
        int               bsy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    shift_unit_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one request at a negedge; capture happens on the following posedge.
    task automatic issue(input logic [1:0] m, input int a, input logic [WIDTH-1:0] d,
                         input logic hold);
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        amount  = AMT_W'(a);
        data_in = d;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        else begin
            mode    = 2'b11;
            amount  = AMT_W'(1);
            data_in = 8'hFF;
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] r, input logic c, input int lat, input int bsy);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.lat = lat;
        e.bsy = bsy;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for done, compare against the oldest expectation, then check the idle cycle after.
    task automatic wait_done(input string tag);
        int   lat;
        int   bcnt;
        bit   seen;
        exp_t e;
        logic [WIDTH-1:0] held;
        lat  = 0;
        bcnt = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_carry"}, 32'(carry_out), 32'(e.c));
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            check({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.bsy));
        end
        held = result;
        @(negedge clk);
        check({tag, "_done_pulse_low"}, 32'(done), 32'd0);
        check({tag, "_idle_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_result_stable"}, 32'(result), 32'(held));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        amount  = '0;
        data_in = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LSL 0x96 by 3
        push_exp(8'hB0, 1'b0, 4, 4);
        issue(2'b00, 3, 8'h96, 1'b0);
        wait_done("lsl3");

        // ASR 0x96 by 2
        push_exp(8'hE5, 1'b1, 3, 3);
        issue(2'b10, 2, 8'h96, 1'b0);
        wait_done("asr2");

        // ROR 0x96 by 11 reduces to 3
        push_exp(8'hD2, 1'b1, 4, 4);
        issue(2'b11, 11, 8'h96, 1'b0);
        wait_done("ror11");

        // LSR by 0: straight to DONE, carry cleared from previous op
        push_exp(8'h5A, 1'b0, 1, 1);
        issue(2'b01, 0, 8'h5A, 1'b0);
        wait_done("lsr0");

        // LSR 0x81 by 12 clamps to 8
        push_exp(8'h00, 1'b1, 9, 9);
        issue(2'b01, 12, 8'h81, 1'b0);
        wait_done("lsr12");

        // ASR 0x80 by 15 clamps to 8: all sign bits, carry is sign
        push_exp(8'hFF, 1'b1, 9, 9);
        issue(2'b10, 15, 8'h80, 1'b0);
        wait_done("asr15");

        // start held high through LSL 0x01 by 5; only the first is taken
        push_exp(8'h20, 1'b0, 6, 6);
        issue(2'b00, 5, 8'h01, 1'b1);
        wait_done("lsl5_held");
        // now in the first IDLE cycle with start still high: present the next op
        mode    = 2'b00;
        amount  = AMT_W'(1);
        data_in = 8'h03;
        push_exp(8'h06, 1'b0, 1, 1);
        @(negedge clk);
        check("first_idle_accept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("lsl1_b2b");

        // asynchronous reset in the middle of ROR 0xF0 by 6, after two shifts
        @(negedge clk);
        start   = 1'b1;
        mode    = 2'b11;
        amount  = AMT_W'(6);
        data_in = 8'hF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_carry", 32'(carry_out), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        push_exp(8'h06, 1'b0, 2, 2);
        issue(2'b00, 1, 8'h03, 1'b0);
        wait_done("lsl1_after_rst");

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
